// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, BIST polynomials and FSM encoding.
// Imported by the ALU BIST controller and its LFSR.
package alu_pkg;

    localparam int          ALU_WIDTH = 16;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [15:0] MISR_POLY = 16'h1021;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        CHECK,
        DONE
    } bist_state_t;

endpackage

// File: rtl/alu_lfsr32.sv
// 32-bit right-shifting Galois LFSR with seed load and advance enable.
// A zero seed would lock the register, so it is replaced by 1.
module alu_lfsr32
    import alu_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        adv,
    output logic [31:0] q
);

    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

    logic [31:0] q_next;

    always_comb begin
        q_next = (q >> 1) ^ (q[0] ? LFSR_TAPS : 32'h0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= 32'h0;
        end else if (load) begin
            q <= SEED_EFF;
        end else if (adv) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/alu_bist_ctrl.sv
// BIST engine for the ALU NOR gate: drives LFSR operands, checks against
// a NOR reference and compacts every result into a 16-bit MISR.
module alu_bist_ctrl
    import alu_pkg::*;
#(
    parameter int          WIDTH       = 16,
    parameter int          NUM_VECTORS = 20,
    parameter logic [31:0] SEED        = 32'h0000_0001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic [15:0]      signature
);

    localparam logic [15:0] LAST_VEC = 16'(NUM_VECTORS - 1);

    bist_state_t state, state_n;

    logic [31:0] lfsr;
    logic        load;
    logic        adv;
    logic        last;
    logic        mismatch;
    logic [15:0] vec_cnt;
    logic [7:0]  err_n;
    logic [15:0] sig_n;

    // Operands come straight from the LFSR register, so they stay registered.
    alu_lfsr32 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .adv   (adv),
        .q     (lfsr)
    );

    assign op_a = lfsr[31:16];
    assign op_b = lfsr[15:0];

    assign last     = (vec_cnt == LAST_VEC);
    assign mismatch = (dut_out != ~(op_a | op_b));

    always_comb begin
        err_n = err_count;
        if (mismatch && err_count != 8'hFF) begin
            err_n = err_count + 8'd1;
        end
        sig_n = {signature[14:0], 1'b0}
              ^ (signature[15] ? MISR_POLY : 16'h0)
              ^ dut_out;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = APPLY;
            APPLY:   state_n = CHECK;
            CHECK:   state_n = last ? DONE : APPLY;
            DONE:    if (start) state_n = APPLY;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == APPLY) || (state == CHECK);
        done = (state == DONE);
        load = ((state == IDLE) || (state == DONE)) && start;
        adv  = (state == CHECK) && !last;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_cnt   <= 16'h0;
            err_count <= 8'h0;
            signature <= 16'h0;
            pass      <= 1'b0;
        end else if (load) begin
            vec_cnt   <= 16'h0;
            err_count <= 8'h0;
            signature <= 16'h0;
            pass      <= 1'b0;
        end else if (state == CHECK) begin
            err_count <= err_n;
            signature <= sig_n;
            if (last) begin
                pass <= (err_n == 8'h0);
            end else begin
                vec_cnt <= vec_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Directed bench for alu_bist_ctrl: a NOR gate model with injectable
// faults sits on dut_out; a second instance covers error saturation.
module tb_alu_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] op_a, op_b, dut_out;
    logic        busy, done, pass;
    logic [7:0]  err_count;
    logic [15:0] signature;

    logic        start2 = 1'b0;
    logic [15:0] op_a2, op_b2;
    logic        busy2, done2, pass2;
    logic [7:0]  err2;
    logic [15:0] sig2;

    int mode = 0;
    int vectors = 0;
    int miscompares = 0;
    int n;
    logic [15:0] golden;

    always #5 clk = ~clk;

    always_comb begin
        dut_out = ~(op_a | op_b);
        if (mode == 1) dut_out = 16'h0000;
        if (mode == 2 && op_a == 16'h0000 && op_b == 16'h0001)
            dut_out = dut_out ^ 16'h0001;
    end

    alu_bist_ctrl u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .dut_out   (dut_out),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .signature (signature)
    );

    alu_bist_ctrl #(.NUM_VECTORS(300)) u_big (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start2),
        .op_a      (op_a2),
        .op_b      (op_b2),
        .dut_out   (16'h0000),
        .busy      (busy2),
        .done      (done2),
        .pass      (pass2),
        .err_count (err2),
        .signature (sig2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sig_model(input int m, input int nv);
        logic [31:0] l = 32'h1;
        logic [15:0] s = 16'h0;
        logic [15:0] o;
        for (int k = 0; k < nv; k++) begin
            o = ~(l[31:16] | l[15:0]);
            if (m == 1) o = 16'h0;
            if (m == 2 && k == 0) o = o ^ 16'h1;
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0) ^ o;
            l = (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge; returns just after the accepting edge.
    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        n = 0;
        while (!done && n < limit) begin
            tick();
            n++;
            if (n == 2) chk({tag, " vec1"}, {op_a, op_b}, 32'h8020_0003);
        end
        chk({tag, " latency"}, n, 40);
    endtask

    initial begin
        golden = sig_model(0, 20);
        tick();
        tick();
        chk("reset outs", {busy, done, pass, err_count, signature, op_a, op_b},
            '0);
        rst_n = 1'b1;
        tick();

        mode = 0;
        kick();
        chk("run busy", busy, 1'b1);
        chk("vec0 ops", {op_a, op_b}, 32'h0000_0001);
        chk("vec0 out", dut_out, 16'hFFFE);
        wait_done("golden", 100);
        chk("golden pass", pass, 1'b1);
        chk("golden err", err_count, 8'd0);
        chk("golden sig", signature, golden);
        chk("golden busy", busy, 1'b0);
        tick();
        chk("done hold", {done, pass}, 2'b11);

        mode = 1;
        kick();
        wait_done("stuck", 100);
        chk("stuck pass", pass, 1'b0);
        chk("stuck err", err_count, 8'd20);
        chk("stuck sig", signature, sig_model(1, 20));
        chk("stuck sig differs", signature != golden, 1'b1);

        mode = 2;
        kick();
        wait_done("flip0", 100);
        chk("flip0 err", err_count, 8'd1);
        chk("flip0 pass", pass, 1'b0);
        chk("flip0 sig", signature, sig_model(2, 20));

        mode = 0;
        kick();
        repeat (15) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst outs",
            {busy, done, pass, err_count, signature, op_a, op_b}, '0);
        tick();
        chk("midrst idle", {busy, done}, 2'b00);
        kick();
        chk("rerun vec0", {op_a, op_b}, 32'h0000_0001);
        wait_done("rerun", 100);
        chk("rerun sig", signature, golden);
        chk("rerun pass", pass, 1'b1);

        kick();
        repeat (5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ignored busy", busy, 1'b1);
        n = 6;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        chk("ignored latency", n, 40);

        start = 1'b1;
        tick();
        wait_done("held", 100);
        tick();
        chk("held done 1cyc", done, 1'b0);
        chk("held busy", busy, 1'b1);
        chk("held vec0", {op_a, op_b}, 32'h0000_0001);
        start = 1'b0;

        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 1000) begin
            tick();
            n++;
        end
        chk("big latency", n, 600);
        chk("big err sat", err2, 8'd255);
        chk("big pass", pass2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
